// File: rtl/mem_access_unit_pkg.sv
// mem_defs: shared state, width codes and legality helper
// for the memory access stage.
package mem_defs;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } mas_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Width code must exist for the access kind and the
  // byte offset must be naturally aligned for that width.
  function automatic logic access_legal(
    input logic       fetch,
    input logic       write,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic ok;
    ok = 1'b0;
    if (fetch) begin
      ok = (off == 2'b00);
    end else begin
      case (f3)
        F3_B:    ok = 1'b1;
        F3_H:    ok = !off[0];
        F3_W:    ok = (off == 2'b00);
        F3_BU:   ok = !write;
        F3_HU:   ok = !write && !off[0];
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// load_extend: picks the byte/half lane of a read word and
// sign/zero extends it. Ports: rdata, offset, funct3 -> ext.
module load_extend
  import mem_defs::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    ext = rdata;
    case (funct3)
      F3_B:    ext = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    ext = {{16{half_sel[15]}}, half_sel};
      F3_BU:   ext = {24'd0, byte_sel};
      F3_HU:   ext = {16'd0, half_sel};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: fetch/load/store against unified memory via
// req/ack; holds IR and extended load data, pulses done/fault.
// Ports: req_* from control FSM, mem_* to memory, done/fault/busy,
// instr_o, rdata_o. All outputs registered.
module mem_access_unit
  import mem_defs::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] NOP_INSTR = mem_defs::NOP_INSTR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_fetch,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_funct3,
  output logic              done,
  output logic              fault,
  output logic              busy,
  output logic [31:0]       instr_o,
  output logic [31:0]       rdata_o,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  mas_state_t        state_q, state_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;
  logic              busy_q, busy_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [15:0]       timer_q, timer_d;
  logic              fetch_q, fetch_d;
  logic              write_q, write_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;

  logic              is_write;
  logic              legal;
  logic [3:0]        st_strb;
  logic [31:0]       st_data;
  logic [31:0]       ld_ext;

  load_extend u_ext (
    .rdata  (mem_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .ext    (ld_ext)
  );

  // Store lane steering from the incoming request.
  always_comb begin
    is_write = req_write && !req_fetch;
    legal    = access_legal(req_fetch, is_write,
                            req_funct3, req_addr[1:0]);
    st_strb  = 4'b0000;
    st_data  = 32'd0;
    if (is_write) begin
      case (req_funct3)
        F3_B: begin
          st_strb = 4'b0001 << req_addr[1:0];
          st_data = {4{req_wdata[7:0]}};
        end
        F3_H: begin
          st_strb = req_addr[1] ? 4'b1100 : 4'b0011;
          st_data = {2{req_wdata[15:0]}};
        end
        default: begin
          st_strb = 4'b1111;
          st_data = req_wdata;
        end
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    fault_d    = 1'b0;
    instr_d    = instr_q;
    rdata_d    = rdata_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    wstrb_d    = wstrb_q;
    wdata_d    = wdata_q;
    timer_d    = timer_q;
    fetch_d    = fetch_q;
    write_d    = write_q;
    f3_d       = f3_q;
    off_d      = off_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          fetch_d = req_fetch;
          write_d = is_write;
          f3_d    = req_funct3;
          off_d   = req_addr[1:0];
          timer_d = 16'd0;
          if (legal) begin
            state_d    = WAIT;
            mem_req_d  = 1'b1;
            mem_we_d   = is_write;
            mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
            wstrb_d    = st_strb;
            wdata_d    = st_data;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end
        end
      end
      WAIT: begin
        // Ack takes priority over an expiring timer.
        if (mem_ack) begin
          state_d   = DONE;
          done_d    = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (fetch_q) begin
            instr_d = mem_rdata;
          end else if (!write_q) begin
            rdata_d = ld_ext;
          end
        end else if (timer_q == TMO_LAST) begin
          state_d   = DONE;
          done_d    = 1'b1;
          fault_d   = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = 16'd0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      busy_q     <= 1'b0;
      instr_q    <= NOP_INSTR;
      rdata_q    <= 32'd0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      wstrb_q    <= 4'b0000;
      wdata_q    <= 32'd0;
      timer_q    <= 16'd0;
      fetch_q    <= 1'b0;
      write_q    <= 1'b0;
      f3_q       <= 3'b000;
      off_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
      busy_q     <= busy_d;
      instr_q    <= instr_d;
      rdata_q    <= rdata_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      wstrb_q    <= wstrb_d;
      wdata_q    <= wdata_d;
      timer_q    <= timer_d;
      fetch_q    <= fetch_d;
      write_q    <= write_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
    end
  end

  assign done      = done_q;
  assign fault     = fault_q;
  assign busy      = busy_q;
  assign instr_o   = instr_q;
  assign rdata_o   = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wstrb = wstrb_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vectors for fetch, loads, stores,
// illegal requests, timeout and async reset of mem_access_unit.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        req_valid, req_fetch, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        done, fault, busy;
  logic [31:0] instr_o, rdata_o;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;

  int n_vec = 0;
  int n_err = 0;

  logic        o_req, o_we, o_done, o_fault, o_req_end;
  logic        o_done_after, o_busy_after;
  logic [31:0] o_addr, o_wdata;
  logic [3:0]  o_strb;

  mem_access_unit #(
    .ADDR_W  (32),
    .TIMEOUT (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_fetch  (req_fetch),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .done       (done),
    .fault      (fault),
    .busy       (busy),
    .instr_o    (instr_o),
    .rdata_o    (rdata_o),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request; ack_at=0 means no ack is given.
  // Records bus state in cycle 1 and done/fault in the
  // cycle after the ack (or cycle 1 when no ack).
  task automatic run_access(
    input logic        f,
    input logic        w,
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic [2:0]  f3,
    input logic [31:0] rd,
    input int          ack_at
  );
    @(negedge clk);
    req_fetch  = f;
    req_write  = w;
    req_addr   = a;
    req_wdata  = wd;
    req_funct3 = f3;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    o_req   = mem_req;
    o_we    = mem_we;
    o_addr  = mem_addr;
    o_strb  = mem_wstrb;
    o_wdata = mem_wdata;
    if (ack_at > 0) begin
      for (int c = 1; c < ack_at; c++) begin
        @(posedge clk); #1;
      end
      mem_ack   = 1'b1;
      mem_rdata = rd;
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    o_done    = done;
    o_fault   = fault;
    o_req_end = mem_req;
    @(posedge clk); #1;
    o_done_after = done;
    o_busy_after = busy;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1;
    n_vec++;
    if ({done, fault, busy, mem_req, mem_we} !== 5'b0) begin
      n_err++;
      $display("FAIL rst_ctl got %b want 00000",
               {done, fault, busy, mem_req, mem_we});
    end
    n_vec++;
    if (instr_o !== 32'h0000_0013) begin
      n_err++;
      $display("FAIL rst_ir got %h want 00000013", instr_o);
    end
    n_vec++;
    if ({rdata_o, mem_addr, mem_wdata, mem_wstrb} !== 100'd0) begin
      n_err++;
      $display("FAIL rst_data got %h %h %h %b want 0",
               rdata_o, mem_addr, mem_wdata, mem_wstrb);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_fetch;
    run_access(1'b1, 1'b0, 32'h100, 32'h0, 3'b111,
               32'h0050_0093, 3);
    n_vec++;
    if ({o_req, o_we} !== 2'b10 || o_addr !== 32'h100) begin
      n_err++;
      $display("FAIL fetch_bus got req=%b we=%b a=%h want 1 0 100",
               o_req, o_we, o_addr);
    end
    n_vec++;
    if ({o_done, o_fault, o_req_end} !== 3'b100) begin
      n_err++;
      $display("FAIL fetch_done got %b want 100",
               {o_done, o_fault, o_req_end});
    end
    n_vec++;
    if (instr_o !== 32'h0050_0093) begin
      n_err++;
      $display("FAIL fetch_ir got %h want 00500093", instr_o);
    end
    n_vec++;
    if ({o_done_after, o_busy_after} !== 2'b00) begin
      n_err++;
      $display("FAIL fetch_pulse got %b want 00",
               {o_done_after, o_busy_after});
    end
  endtask

  task automatic test_loads;
    run_access(1'b0, 1'b0, 32'h203, 32'h0, 3'b000,
               32'h80FF_0000, 2);
    n_vec++;
    if (rdata_o !== 32'hFFFF_FF80 || o_addr !== 32'h200) begin
      n_err++;
      $display("FAIL lb got %h a=%h want ffffff80 200",
               rdata_o, o_addr);
    end
    run_access(1'b0, 1'b0, 32'h203, 32'h0, 3'b100,
               32'h80FF_0000, 2);
    n_vec++;
    if (rdata_o !== 32'h0000_0080) begin
      n_err++;
      $display("FAIL lbu got %h want 00000080", rdata_o);
    end
    run_access(1'b0, 1'b0, 32'h202, 32'h0, 3'b101,
               32'h80FF_0000, 1);
    n_vec++;
    if (rdata_o !== 32'h0000_80FF) begin
      n_err++;
      $display("FAIL lhu got %h want 000080ff", rdata_o);
    end
    run_access(1'b0, 1'b0, 32'h202, 32'h0, 3'b001,
               32'h80FF_0000, 1);
    n_vec++;
    if (rdata_o !== 32'hFFFF_80FF) begin
      n_err++;
      $display("FAIL lh got %h want ffff80ff", rdata_o);
    end
    run_access(1'b0, 1'b0, 32'h204, 32'h0, 3'b010,
               32'hDEAD_BEEF, 1);
    n_vec++;
    if (rdata_o !== 32'hDEAD_BEEF || o_strb !== 4'b0000) begin
      n_err++;
      $display("FAIL lw got %h s=%b want deadbeef 0000",
               rdata_o, o_strb);
    end
  endtask

  task automatic test_stores;
    logic [31:0] keep;
    keep = rdata_o;
    run_access(1'b0, 1'b1, 32'h41, 32'h1234_56AB, 3'b000,
               32'h5555_5555, 2);
    n_vec++;
    if (o_strb !== 4'b0010 || o_wdata !== 32'hABAB_ABAB ||
        o_addr !== 32'h40 || o_we !== 1'b1) begin
      n_err++;
      $display("FAIL sb got s=%b d=%h a=%h we=%b want 0010 abababab 40 1",
               o_strb, o_wdata, o_addr, o_we);
    end
    run_access(1'b0, 1'b1, 32'h42, 32'h1234_56AB, 3'b001,
               32'h5555_5555, 2);
    n_vec++;
    if (o_strb !== 4'b1100 || o_wdata !== 32'h56AB_56AB ||
        o_addr !== 32'h40) begin
      n_err++;
      $display("FAIL sh got s=%b d=%h a=%h want 1100 56ab56ab 40",
               o_strb, o_wdata, o_addr);
    end
    run_access(1'b0, 1'b1, 32'h44, 32'h1234_56AB, 3'b010,
               32'h5555_5555, 1);
    n_vec++;
    if (o_strb !== 4'b1111 || o_wdata !== 32'h1234_56AB ||
        {o_done, o_fault} !== 2'b10) begin
      n_err++;
      $display("FAIL sw got s=%b d=%h df=%b want 1111 123456ab 10",
               o_strb, o_wdata, {o_done, o_fault});
    end
    n_vec++;
    if (rdata_o !== keep) begin
      n_err++;
      $display("FAIL st_keep got %h want %h", rdata_o, keep);
    end
  endtask

  task automatic test_illegal;
    run_access(1'b0, 1'b0, 32'h06, 32'h0, 3'b010, 32'h0, 0);
    n_vec++;
    if ({o_req, o_done, o_fault} !== 3'b011) begin
      n_err++;
      $display("FAIL lw_misal got %b want 011",
               {o_req, o_done, o_fault});
    end
    run_access(1'b0, 1'b0, 32'h08, 32'h0, 3'b011, 32'h0, 0);
    n_vec++;
    if ({o_req, o_done, o_fault} !== 3'b011) begin
      n_err++;
      $display("FAIL ld_f3 got %b want 011",
               {o_req, o_done, o_fault});
    end
    run_access(1'b0, 1'b1, 32'h08, 32'h0, 3'b100, 32'h0, 0);
    n_vec++;
    if ({o_req, o_done, o_fault} !== 3'b011) begin
      n_err++;
      $display("FAIL st_f3 got %b want 011",
               {o_req, o_done, o_fault});
    end
    run_access(1'b1, 1'b0, 32'h102, 32'h0, 3'b000, 32'h0, 0);
    n_vec++;
    if ({o_req, o_done, o_fault, o_done_after} !== 4'b0110) begin
      n_err++;
      $display("FAIL fetch_misal got %b want 0110",
               {o_req, o_done, o_fault, o_done_after});
    end
  endtask

  task automatic test_timeout;
    logic [31:0] keep;
    int          hi;
    keep = rdata_o;
    hi   = 0;
    @(negedge clk);
    req_fetch  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'h300;
    req_funct3 = 3'b010;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (mem_req === 1'b1 && done === 1'b0) hi++;
      @(posedge clk); #1;
    end
    n_vec++;
    if (hi !== 4) begin
      n_err++;
      $display("FAIL tmo_req_cycles got %0d want 4", hi);
    end
    n_vec++;
    if ({mem_req, done, fault} !== 3'b011 || rdata_o !== keep) begin
      n_err++;
      $display("FAIL tmo_done got %b r=%h want 011 %h",
               {mem_req, done, fault}, rdata_o, keep);
    end
    @(posedge clk); #1;
    run_access(1'b0, 1'b0, 32'h300, 32'h0, 3'b010,
               32'hCAFE_F00D, 4);
    n_vec++;
    if ({o_done, o_fault} !== 2'b10 || rdata_o !== 32'hCAFE_F00D) begin
      n_err++;
      $display("FAIL ack_at_tmo got %b r=%h want 10 cafef00d",
               {o_done, o_fault}, rdata_o);
    end
  endtask

  task automatic test_reset_mid_wait;
    @(negedge clk);
    req_fetch = 1'b1;
    req_addr  = 32'h400;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (mem_req !== 1'b1) begin
      n_err++;
      $display("FAIL rw_pre got %b want 1", mem_req);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if ({mem_req, busy} !== 2'b00 || instr_o !== 32'h0000_0013) begin
      n_err++;
      $display("FAIL rw_async got %b ir=%h want 00 00000013",
               {mem_req, busy}, instr_o);
    end
    @(negedge clk);
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({done, mem_req, busy} !== 3'b000 ||
        instr_o !== 32'h0000_0013) begin
      n_err++;
      $display("FAIL rw_late_ack got %b ir=%h want 000 00000013",
               {done, mem_req, busy}, instr_o);
    end
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_fetch  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_funct3 = 3'b000;
    mem_rdata  = 32'h0;
    mem_ack    = 1'b0;
    @(posedge clk); #1;
    test_reset;
    test_fetch;
    test_loads;
    test_stores;
    test_illegal;
    test_timeout;
    test_reset_mid_wait;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory access stage directly downstream of the multicycle control FSM. It performs every instruction fetch, load and store against the single unified instruction/data memory through a request/acknowledge handshake. It captures the instruction register and the byte/half/word-aligned, extended load-data register, and returns a one-cycle done pulse so the FSM can advance. Adds lb/lh/lbu/lhu/sb/sh support alongside lw/sw.

Parameters:
ADDR_W, 32, byte-address width
TIMEOUT, 255, max cycles waiting for mem_ack before faulting (1..65535)
NOP_INSTR, 32'h0000_0013, instruction register reset value (addi x0,x0,0)

Ports:
clk  in  1  clock
reset  in  1  reset; one clock, asynchronous, active-high
req_valid  in  1  FSM starts an access (sampled only in IDLE)
req_fetch  in  1  1 = instruction fetch, 0 = data access
req_write  in  1  1 = store (ignored when req_fetch=1)
req_addr  in  ADDR_W  byte address (already muxed PC/ALUOut)
req_wdata  in  32  store data (rs2)
req_funct3  in  3  load/store width/sign code
done  out  1  one-cycle pulse: access finished
fault  out  1  valid with done: misaligned, illegal funct3 or timeout
busy  out  1  high in every state except IDLE
instr_o  out  32  instruction register
rdata_o  out  32  aligned, extended load data
mem_req  out  1  memory request, held until ack
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
mem_wstrb  out  4  byte-lane write strobes
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  read data, valid with mem_ack
mem_ack  in  1  memory completes request

Behaviour:
- Reset (async, immediate): state IDLE; done=fault=busy=mem_req=mem_we=0; mem_addr=0, mem_wstrb=0, mem_wdata=0; instr_o=NOP_INSTR; rdata_o=0; timer=0. Reset mid-WAIT drops mem_req immediately; that transaction is abandoned.
- States: IDLE, WAIT, DONE. All outputs are registered.
- IDLE: on req_valid, latch request fields and check legality:
  - Fetch: addr[1:0] must be 00; funct3 ignored.
  - Load funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Store funct3: 000 sb, 001 sh, 010 sw. Any other code is illegal.
  - Half requires addr[0]=0; word requires addr[1:0]=00.
  - Illegal/misaligned: go to DONE with fault=1; no memory request is issued.
  - Legal: go to WAIT; mem_req=1 from the next cycle.
- WAIT: mem_req, mem_we, mem_addr, mem_wstrb and mem_wdata stay stable until mem_ack. Timer increments each cycle.
  - On mem_ack: fetch loads instr_o<=mem_rdata; load loads rdata_o<=extended lane; store updates neither register. Drop mem_req and go to DONE with fault=0.
  - If timer reaches TIMEOUT with no ack: drop mem_req and go to DONE with fault=1; instr_o/rdata_o unchanged.
  - If ack arrives in the same cycle the timer hits TIMEOUT, ack wins.
- DONE: done=1 for exactly one cycle (fault valid with it), then IDLE, timer cleared.
- req_valid outside IDLE is ignored, not queued. mem_ack outside WAIT is ignored.
- Store lanes: sb gives wstrb=1<<addr[1:0] and wdata={4{wdata[7:0]}}. sh gives wstrb=0011 or 1100 and wdata={2{wdata[15:0]}}. sw gives 1111. Loads and fetches use wstrb=0000, we=0.
- Load extend: select byte addr[1:0] or half addr[1]. lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
- Latency: request accepted at cycle 0, mem_req high cycles 1..k (ack at k), done at k+1. Zero-wait memory (ack in cycle 1) gives done at cycle 2. Illegal request gives done+fault at cycle 1.

Decomposition:
- Package mem_defs holds: state enum mas_state_t {IDLE,WAIT,DONE}; funct3 localparams F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101; NOP_INSTR constant.
- Sub-module load_extend (combinational): inputs rdata[31:0], offset[1:0], funct3; output the extended 32-bit value. The store lane/strobe generation stays inline.

Test Plan:
- Fetch addr 0x100, ack after 3 cycles with rdata 0x00500093 -> mem_addr=0x100, we=0; instr_o=0x00500093; done at cycle 4, fault=0.
- lb addr 0x203, rdata 0x80FF_0000 -> rdata_o=0xFFFF_FF80; lbu same -> 0x0000_0080; lhu addr 0x202 -> 0x0000_80FF.
- sb addr 0x41, wdata 0x1234_56AB -> wstrb=0010, mem_wdata=0xABABABAB, mem_addr=0x40; sh addr 0x42 -> wstrb=1100, wdata=0x56AB56AB.
- lw addr 0x06 or funct3=011 -> no mem_req; done=1 and fault=1 at cycle 1.
- TIMEOUT=4 with no ack -> mem_req high 4 cycles then low; done+fault next cycle; rdata_o unchanged.
- Assert reset during WAIT -> mem_req falls the same cycle without a clock edge; instr_o=0x00000013; a late ack is ignored; busy=0.
